// File: rtl/ripple_count_ctrl_if.sv
// Command handshake bundle for ripple_count_ctrl: host drives valid/op/target, controller
// returns ready.
interface ripple_count_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_target;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_target,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_target,
        output cmd_ready
    );
endinterface

// File: rtl/ripple_count_ctrl.sv
// Sequencer for a T-flip-flop ripple counter: clear, tick, settle, sample until target.
// Optional shadow-count cross-check enabled by defining RIPPLE_CTRL_CHECK_EN.
module ripple_count_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CLR_CYC    = 1
) (
    input  logic              clock,
    input  logic              clear_n,
    ripple_count_ctrl_if.slave cmd,
    input  logic              abort,
    output logic              cnt_clear,
    output logic              cnt_tick,
    input  logic [WIDTH-1:0]  cnt_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CycMax = (SETTLE_CYC > CLR_CYC) ? SETTLE_CYC : CLR_CYC;
    localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;

    localparam logic [1:0] OpStart = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StWait,
        StTick,
        StDone,
        StError
    } state_e;

    state_e           state_q;
    logic [CycW-1:0]  cyc_q;
    logic [WIDTH-1:0] target_q;
    logic             is_start_q;
    logic             accept;

    assign cmd.cmd_ready = clear_n &&
                           (state_q == StIdle || state_q == StDone || state_q == StError);
    assign accept = cmd.cmd_valid && cmd.cmd_ready;

`ifdef RIPPLE_CTRL_CHECK_EN
    logic [WIDTH-1:0] shadow_q;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= StIdle;
            cyc_q      <= '0;
            target_q   <= '0;
            is_start_q <= 1'b0;
            cnt_clear  <= 1'b0;
            cnt_tick   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef RIPPLE_CTRL_CHECK_EN
            shadow_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // Tick is a single-cycle pulse; only the WAIT->TICK transition raises it.
            cnt_tick <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (accept) begin
                        done <= 1'b0;
`ifdef RIPPLE_CTRL_CHECK_EN
                        err_q <= 1'b0;
`endif
                        if (cmd.cmd_op == OpStart || cmd.cmd_op == OpClear) begin
                            is_start_q <= (cmd.cmd_op == OpStart);
                            if (cmd.cmd_op == OpStart) begin
                                target_q <= cmd.cmd_target;
                            end
                            state_q   <= StClr;
                            cyc_q     <= CycW'(CLR_CYC - 1);
                            cnt_clear <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StClr: begin
`ifdef RIPPLE_CTRL_CHECK_EN
                    shadow_q <= '0;
`endif
                    if (abort) begin
                        state_q   <= StIdle;
                        cnt_clear <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (cyc_q == '0) begin
                        cnt_clear <= 1'b0;
                        if (is_start_q) begin
                            state_q <= StWait;
                            cyc_q   <= CycW'(SETTLE_CYC - 1);
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cyc_q <= cyc_q - CycW'(1);
                    end
                end
                StWait: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (cyc_q != '0) begin
                        cyc_q <= cyc_q - CycW'(1);
`ifdef RIPPLE_CTRL_CHECK_EN
                    end else if (cnt_q != shadow_q) begin
                        state_q <= StError;
                        err_q   <= 1'b1;
                        busy    <= 1'b0;
`endif
                    end else if (cnt_q == target_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_q  <= StTick;
                        cnt_tick <= 1'b1;
                    end
                end
                StTick: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        state_q <= StWait;
                        cyc_q   <= CycW'(SETTLE_CYC - 1);
`ifdef RIPPLE_CTRL_CHECK_EN
                        shadow_q <= shadow_q + WIDTH'(1);
`endif
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_clear <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
